// File: rtl/dpram_fwft_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external single-clock true
// dual-port RAM whose reads are registered with a latency of one cycle.
// Port A of the RAM is the write port and port B is the read port. A two-entry
// output buffer (head + skid) gives the consumer registered data and full pop
// throughput.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   push, din      write request and data; dropped while full
//   full           no RAM slot free (RAM words + in-flight fetch == DEPTH)
//   pop            consume the head word
//   dout           head word; valid when dout_valid
//   dout_valid     head holds a word; empty is its complement
//   level          total words held: RAM + in-flight + output buffer
//   overflow       sticky: push while full
//   underflow      sticky: pop while !dout_valid
//   ram_*_a        RAM write port (address = write pointer)
//   ram_*_b        RAM read port (address = read pointer, write tied off)
//   ram_dout_b     RAM read data, valid the cycle after the address
module dpram_fwft_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic                  ram_we_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned LW    = ADDR_WIDTH + 2;

    localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CntOne   = CW'(1);
    localparam logic [CW-1:0]         CntDepth = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_acc;
    logic                  pop_acc;
    logic                  fetch;
    logic [2:0]            stage_cnt;
    logic [CW-1:0]         occ_d;

    assign wr_acc  = push & ~full_q;
    assign pop_acc = pop & valid_q;

    // Words already out of the RAM: output buffer plus the fetch in flight.
    assign stage_cnt = {1'b0, out_cnt_q} + {2'b00, inflight_q};

    // Fetch only if the word it returns next cycle is guaranteed a buffer slot,
    // counting the slot a pop frees in this same cycle.
    assign fetch = (ram_cnt_q != '0) && (stage_cnt < (3'd2 + {2'b00, pop_acc}));

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = fetch;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({wr_acc, fetch})
            2'b10:   ram_cnt_d = ram_cnt_q + CntOne;
            2'b01:   ram_cnt_d = ram_cnt_q - CntOne;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // A RAM slot counts as occupied until its fetch has returned.
        occ_d  = ram_cnt_d + {{ADDR_WIDTH{1'b0}}, inflight_d};
        full_d = (occ_d == CntDepth);

        overflow_d  = overflow_q | (push & full_q);
        underflow_d = underflow_q | (pop & ~valid_q);
    end

    // Output buffer: head is always the oldest word, skid the next one.
    always_comb begin
        head_d    = head_q;
        skid_d    = skid_q;
        out_cnt_d = out_cnt_q;

        if (pop_acc) begin
            if (out_cnt_q == 2'd2) begin
                head_d = skid_q;
                if (inflight_q) begin
                    skid_d = ram_dout_b;
                end else begin
                    out_cnt_d = 2'd1;
                end
            end else begin
                if (inflight_q) begin
                    head_d = ram_dout_b;
                end else begin
                    out_cnt_d = 2'd0;
                end
            end
        end else if (inflight_q) begin
            // The fetch rule keeps out_cnt below 2 whenever a return lands
            // without a pop, so the return always has a free slot.
            if (out_cnt_q == 2'd0) begin
                head_d = ram_dout_b;
            end else begin
                skid_d = ram_dout_b;
            end
            out_cnt_d = out_cnt_q + 2'd1;
        end

        valid_d = (out_cnt_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            out_cnt_q   <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
            valid_q     <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            inflight_q  <= inflight_d;
            out_cnt_q   <= out_cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            valid_q     <= valid_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign full       = full_q;
    assign dout       = head_q;
    assign dout_valid = valid_q;
    assign empty      = ~valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    assign level = {1'b0, ram_cnt_q}
                 + {{(LW - 1){1'b0}}, inflight_q}
                 + {{(LW - 2){1'b0}}, out_cnt_q};

    assign ram_addr_a = wr_ptr_q;
    assign ram_we_a   = wr_acc;
    assign ram_din_a  = din;
    assign ram_addr_b = rd_ptr_q;
    assign ram_we_b   = 1'b0;
    assign ram_din_b  = '0;

endmodule

// File: tb/tb_dpram_fwft_fifo_ctrl.sv
// Self-checking bench for dpram_fwft_fifo_ctrl: a behavioural RAM, a
// queue-based reference model, directed scenarios and randomized traffic.
module tb_dpram_fwft_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] din;
    logic          full;
    logic          pop;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          empty;
    logic [AW+1:0] level;
    logic          overflow;
    logic          underflow;
    logic [AW-1:0] ram_addr_a;
    logic          ram_we_a;
    logic [DW-1:0] ram_din_a;
    logic [AW-1:0] ram_addr_b;
    logic          ram_we_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b;

    always #5 clk = ~clk;

    dpram_fwft_fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (din),
        .full       (full),
        .pop        (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_din_a  (ram_din_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    // Behavioural dual-port RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    // Reference model: words held in order, split by where they live.
    logic [DW-1:0] m_q[$];
    int            m_ram, m_infl, m_out;
    int            m_wr, m_rd;
    bit            m_ovf, m_unf;
    bit            m_init = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ram  = 0;
        m_infl = 0;
        m_out  = 0;
        m_wr   = 0;
        m_rd   = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_init = 1'b1;
    endtask

    // One clock cycle: drive inputs, check against the model, advance both.
    task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit r);
        bit exp_full, acc, popa, fetch;
        push = p;
        pop  = q;
        din  = d;
        rst  = r;
        #1;
        exp_full = (m_ram + m_infl == DEPTH);
        acc      = p && !exp_full;
        popa     = q && (m_out > 0);
        fetch    = (m_ram > 0) && ((m_out + m_infl - int'(popa)) < 2);
        if (m_init) begin
            check_eq("dout_valid", 64'(dout_valid), 64'(m_out > 0));
            check_eq("empty", 64'(empty), 64'(m_out == 0));
            if (m_out > 0) check_eq("dout", 64'(dout), 64'(m_q[0]));
            check_eq("level", 64'(level), 64'(m_q.size()));
            check_eq("full", 64'(full), 64'(exp_full));
            check_eq("overflow", 64'(overflow), 64'(m_ovf));
            check_eq("underflow", 64'(underflow), 64'(m_unf));
            check_eq("ram_we_a", 64'(ram_we_a), 64'(acc));
            if (acc) begin
                check_eq("ram_addr_a", 64'(ram_addr_a), 64'(m_wr % DEPTH));
                check_eq("ram_din_a", 64'(ram_din_a), 64'(d));
            end
            if (fetch) check_eq("ram_addr_b", 64'(ram_addr_b), 64'(m_rd % DEPTH));
            check_eq("ram_we_b", 64'(ram_we_b), 64'(0));
            check_eq("ram_din_b", 64'(ram_din_b), 64'(0));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (p && exp_full) m_ovf = 1'b1;
            if (q && m_out == 0) m_unf = 1'b1;
            if (popa) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(d);
                m_wr++;
            end
            m_out  = m_out - int'(popa) + m_infl;
            m_infl = int'(fetch);
            m_ram  = m_ram + int'(acc) - int'(fetch);
            if (fetch) m_rd++;
        end
        @(negedge clk);
    endtask

    initial begin
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        rst  = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("rst_empty", 64'(empty), 64'(1));
        check_eq("rst_level", 64'(level), 64'(0));
        check_eq("rst_dout", 64'(dout), 64'(0));

        // Pop on empty: sticky underflow, nothing else moves.
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("unf_sticky", 64'(underflow), 64'(1));
        check_eq("unf_valid", 64'(dout_valid), 64'(0));
        check_eq("unf_level", 64'(level), 64'(0));

        // Single word latency: pushed at edge t, visible after edge t+2.
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 32'hA5, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("a5_not_yet", 64'(dout_valid), 64'(0));
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("a5_valid", 64'(dout_valid), 64'(1));
        check_eq("a5_dout", 64'(dout), 64'(32'hA5));
        check_eq("a5_level", 64'(level), 64'(1));
        step(1'b0, 1'b1, '0, 1'b0);
        check_eq("a5_empty", 64'(empty), 64'(1));
        check_eq("a5_level0", 64'(level), 64'(0));

        // Fill: 16 RAM + 2 buffered words, pushes 18 and 19 overflow.
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        check_eq("fill_level", 64'(level), 64'(18));
        check_eq("fill_full", 64'(full), 64'(1));
        check_eq("fill_ovf", 64'(overflow), 64'(1));
        for (int i = 0; i < 18; i++) begin
            check_eq("fill_order", 64'(dout), 64'(i));
            step(1'b0, 1'b1, '0, 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("fill_drained", 64'(empty), 64'(1));

        // Streaming push+pop every cycle, pointers wrap several times.
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (i >= 3) begin
                check_eq("stream_valid", 64'(dout_valid), 64'(1));
                check_eq("stream_level", 64'(level), 64'(3));
                check_eq("stream_data", 64'(dout), 64'(i - 3));
            end
            step(1'b1, 1'b1, DW'(i), 1'b0);
        end

        // Reset while a fetch is in flight: no stale word survives.
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'h100 + i), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("mid_rst_valid", 64'(dout_valid), 64'(0));
        check_eq("mid_rst_level", 64'(level), 64'(0));
        check_eq("mid_rst_dout", 64'(dout), 64'(0));
        check_eq("mid_rst_full", 64'(full), 64'(0));
        step(1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("mid_rst_new", 64'(dout), 64'(1));
        check_eq("mid_rst_newv", 64'(dout_valid), 64'(1));
        check_eq("mid_rst_lvl1", 64'(level), 64'(1));

        // Random traffic, balanced then push-heavy to reach full.
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), DW'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
